dmem_access_unit: RTL and testbench

DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

---
 rtl/dmem_access_unit_pkg.sv | 28 ++
 rtl/dmem_lane_align.sv | 42 ++++
 rtl/dmem_access_unit.sv | 127 ++++++++++++
 tb/tb_dmem_access_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_unit_pkg.sv
// Shared memory-access definitions: MemSize encodings used by decode and the data-memory unit.
package dmem_access_unit_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HWORD   = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // Byte-lane mask of an access that starts at lane 0.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE:  return 4'b0001;
            SIZE_HWORD: return 4'b0011;
            SIZE_WORD:  return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE:  return 3'd1;
            SIZE_HWORD: return 3'd2;
            SIZE_WORD:  return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering for the data-memory unit: store byte enables/data per access word,
// and load extraction plus sign/zero extension from the (up to) two read words.
module dmem_lane_align
    import dmem_access_unit_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic        split,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] rdata
);

    logic [7:0]  be_all;
    logic [63:0] wd_all;
    logic [31:0] raw;

    // Treat the two words as one 64-bit little-endian window starting at the first word.
    always_comb begin
        be_all = {4'b0000, size_mask(size)} << offset;
        wd_all = {32'h0000_0000, wdata} << {offset, 3'b000};
        raw    = 32'({word1, word0} >> {offset, 3'b000});
        case (size)
            SIZE_BYTE:  rdata = {{24{sign & raw[7]}}, raw[7:0]};
            SIZE_HWORD: rdata = {{16{sign & raw[15]}}, raw[15:0]};
            default:    rdata = raw;
        endcase
    end

    assign split  = ({1'b0, offset} + size_bytes(size)) > 3'd4;
    assign be0    = be_all[3:0];
    assign be1    = be_all[7:4];
    assign wdata0 = wd_all[31:0];
    assign wdata1 = wd_all[63:32];

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: one byte/half/word load or store per request over a
// 32-bit word SRAM, splitting unaligned accesses that cross a word into two strobes.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_wEn,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-3:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // rsp_valid is a one-cycle pulse with no back-pressure.
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;

    logic              split;
    logic [3:0]        be0, be1;
    logic [31:0]       wdata0, wdata1, load_data, word0_sel;
    logic [ADDR_W-3:0] word_addr;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^(req_addr >> ADDR_W);
    assign word_addr      = addr_q[ADDR_W-1:2];
    // After a split load the first word was parked in lo_q; otherwise it is on sram_rdata.
    assign word0_sel      = (state == RESP && split) ? lo_q : sram_rdata;

    dmem_lane_align u_align (
        .offset (addr_q[1:0]),
        .size   (size_q),
        .sign   (sign_q),
        .wdata  (wdata_q),
        .word0  (word0_sel),
        .word1  (sram_rdata),
        .split  (split),
        .be0    (be0),
        .be1    (be1),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .rdata  (load_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            size_q  <= SIZE_BYTE;
            sign_q  <= 1'b0;
            wdata_q <= '0;
            lo_q    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr[ADDR_W-1:0];
                wen_q   <= req_wEn;
                size_q  <= req_size;
                sign_q  <= req_sign;
                wdata_q <= req_wdata;
            end
            if (state == ACC1) lo_q <= sram_rdata;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        rsp_err    = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = (req_size == SIZE_ILLEGAL) ? RESP : ACC0;
            end
            ACC0: begin
                sram_en    = 1'b1;
                sram_addr  = word_addr;
                sram_we    = wen_q ? be0 : 4'b0000;
                sram_wdata = wen_q ? wdata0 : 32'h0;
                state_next = split ? ACC1 : RESP;
            end
            ACC1: begin
                sram_en    = 1'b1;
                sram_addr  = word_addr + 1'b1;
                sram_we    = wen_q ? be1 : 4'b0000;
                sram_wdata = wen_q ? wdata1 : 32'h0;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_err    = (size_q == SIZE_ILLEGAL);
                rsp_rdata  = (wen_q || size_q == SIZE_ILLEGAL) ? 32'h0 : load_data;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: byte-level reference memory drives a per-cycle
// expected-output queue; literal checks pin load results, latencies and SRAM contents.
module tb_dmem_access_unit;

    localparam int ADDR_W = 16;
    localparam int NBYTES = 1 << ADDR_W;
    localparam int NWORDS = 1 << (ADDR_W - 2);

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              req_wEn;
    logic [1:0]        req_size;
    logic              req_sign;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              sram_en;
    logic [3:0]        sram_we;
    logic [ADDR_W-3:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;

    dmem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wEn    (req_wEn),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // clock / reset
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // SRAM model: synchronous read, per-lane write
    logic [31:0] mem [0:NWORDS-1];
    always @(posedge clock) begin
        if (sram_en) begin
            for (int k = 0; k < 4; k++)
                if (sram_we[k]) mem[sram_addr][8*k +: 8] <= sram_wdata[8*k +: 8];
            sram_rdata <= mem[sram_addr];
        end
    end

    // reference model: flat little-endian byte memory
    logic [7:0] ref_bytes [0:NBYTES-1];

    typedef struct packed {
        logic              ready;
        logic              valid;
        logic              err;
        logic [31:0]       rdata;
        logic              en;
        logic [3:0]        we;
        logic [ADDR_W-3:0] addr;
        logic [31:0]       wdata;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  ce;
    string cur_tag = "reset";
    int    n_vec = 0;
    int    n_err = 0;
    int    accept_cyc = 0;
    int    last_lat = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    // compare process: one expected record per driven cycle
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            logic [31:0] m;
            logic        ok;
            ce = exp_q.pop_front();
            m  = '0;
            for (int k = 0; k < 4; k++) if (ce.we[k]) m[8*k +: 8] = 8'hFF;
            ok = (req_ready === ce.ready) && (rsp_valid === ce.valid) && (rsp_err === ce.err) &&
                 (rsp_rdata === ce.rdata) && (sram_en === ce.en) && (sram_we === ce.we) &&
                 (sram_addr === ce.addr) && ((sram_wdata & m) === (ce.wdata & m));
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL %s cyc %0d: got rdy=%b vld=%b err=%b rd=%h en=%b we=%b ad=%h wd=%h; want rdy=%b vld=%b err=%b rd=%h en=%b we=%b ad=%h wd=%h (lanes %h)",
                         cur_tag, cyc, req_ready, rsp_valid, rsp_err, rsp_rdata, sram_en, sram_we, sram_addr, sram_wdata,
                         ce.ready, ce.valid, ce.err, ce.rdata, ce.en, ce.we, ce.addr, ce.wdata, m);
            end
        end
        if (rsp_valid === 1'b1) begin
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            last_lat   = cyc - accept_cyc;
        end
    end

    function automatic exp_t idle_rec();
        exp_t e;
        e       = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    task automatic cycle(input exp_t e);
        exp_q.push_back(e);
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // driver: one request; rst_at = 1/2 asserts reset during ACC0/ACC1 (0 = none)
    task automatic do_req(input string tag, input logic [31:0] a, input logic wen,
                          input logic [1:0] sz, input logic sg, input logic [31:0] wd,
                          input int rst_at);
        logic [ADDR_W-1:0] ab, ba;
        logic [ADDR_W-3:0] w0;
        logic [3:0]  we0, we1;
        logic [31:0] wd0, wd1, rv;
        int n, off;
        logic split;
        exp_t e;
        cur_tag = tag;
        ab  = a[ADDR_W-1:0];
        off = int'(ab[1:0]);
        w0  = ab[ADDR_W-1:2];
        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
        we0 = '0; we1 = '0; wd0 = '0; wd1 = '0; rv = '0;
        for (int i = 0; i < n; i++) begin
            ba = ab + ADDR_W'(i);
            if (wen) ref_bytes[ba] = wd[8*i +: 8];
            else     rv[8*i +: 8] = ref_bytes[ba];
            if (off + i < 4) begin
                we0[off+i] = 1'b1;
                wd0[8*(off+i) +: 8] = wd[8*i +: 8];
            end else begin
                we1[off+i-4] = 1'b1;
                wd1[8*(off+i-4) +: 8] = wd[8*i +: 8];
            end
        end
        if (!wen && sg && n == 1 && rv[7])  rv[31:8]  = '1;
        if (!wen && sg && n == 2 && rv[15]) rv[31:16] = '1;
        split = (off + n) > 4;

        req_valid = 1'b1; req_addr = a; req_wEn = wen; req_size = sz; req_sign = sg; req_wdata = wd;
        accept_cyc = cyc;
        cycle(idle_rec());
        req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
        if (n == 0) begin
            e = '0; e.valid = 1'b1; e.err = 1'b1;
            cycle(e);
            return;
        end
        e = '0; e.en = 1'b1; e.addr = w0; e.we = wen ? we0 : 4'b0000; e.wdata = wd0;
        if (rst_at == 1) reset = 1'b1;
        cycle(e);
        if (rst_at == 1) begin reset = 1'b0; cycle(idle_rec()); return; end
        if (split) begin
            e = '0; e.en = 1'b1; e.addr = w0 + 1'b1; e.we = wen ? we1 : 4'b0000; e.wdata = wd1;
            if (rst_at == 2) reset = 1'b1;
            cycle(e);
            if (rst_at == 2) begin reset = 1'b0; cycle(idle_rec()); return; end
        end
        e = '0; e.valid = 1'b1; e.rdata = wen ? 32'h0 : rv;
        cycle(e);
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) mem[i] = 32'h0;
        mem[0]        = 32'h4433_2211;
        mem[1]        = 32'h8877_6655;
        mem[NWORDS-1] = 32'hDDCC_BBAA;
        for (int i = 0; i < NBYTES; i++) ref_bytes[i] = mem[i/4][8*(i%4) +: 8];
        sram_rdata = '0;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_wEn = 1'b0;
        req_size = 2'b00; req_sign = 1'b0; req_wdata = '0;
        @(posedge clock); #1;
        cycle(idle_rec());
        chk("reset sram_wdata", sram_wdata, 32'h0);
        reset = 1'b0;
        cycle(idle_rec());

        do_req("lb 3 s", 32'h3, 1'b0, 2'b00, 1'b1, 32'h0, 0);
        chk("lb 3 rdata", last_rdata, 32'h0000_0044);
        chk("lb 3 latency", last_lat, 2);
        do_req("lb 7 s", 32'h7, 1'b0, 2'b00, 1'b1, 32'h0, 0);
        chk("lb 7 s rdata", last_rdata, 32'hFFFF_FF88);
        do_req("lbu 7", 32'h7, 1'b0, 2'b00, 1'b0, 32'h0, 0);
        chk("lbu 7 rdata", last_rdata, 32'h0000_0088);
        do_req("lhu 3", 32'h3, 1'b0, 2'b01, 1'b0, 32'h0, 0);
        chk("lhu 3 rdata", last_rdata, 32'h0000_5544);
        chk("lhu 3 latency", last_lat, 3);
        do_req("lw 2", 32'h2, 1'b0, 2'b10, 1'b1, 32'h0, 0);
        chk("lw 2 rdata", last_rdata, 32'h6655_4433);
        chk("lw 2 latency", last_lat, 3);

        do_req("lw 2 reset", 32'h2, 1'b0, 2'b10, 1'b0, 32'h0, 2);
        do_req("lw 4", 32'h4, 1'b0, 2'b10, 1'b0, 32'h0, 0);
        chk("lw 4 rdata", last_rdata, 32'h8877_6655);
        chk("lw 4 latency", last_lat, 2);

        do_req("sh 3", 32'h3, 1'b1, 2'b01, 1'b0, 32'h0000_ABCD, 0);
        chk("sh mem0", mem[0], 32'hCD33_2211);
        chk("sh mem1", mem[1], 32'h8877_66AB);
        chk("sh rdata", last_rdata, 32'h0);

        do_req("illegal", 32'h5, 1'b0, 2'b11, 1'b0, 32'h0, 0);
        chk("illegal err", {31'b0, last_err}, 32'h1);
        chk("illegal latency", last_lat, 1);

        do_req("lw wrap", 32'h0000_FFFE, 1'b0, 2'b10, 1'b0, 32'h0, 0);
        chk("lw wrap rdata", last_rdata, 32'h2211_DDCC);
        do_req("lh 6 s", 32'h6, 1'b0, 2'b01, 1'b1, 32'h0, 0);
        chk("lh 6 rdata", last_rdata, 32'hFFFF_8877);
        do_req("lh 5 s", 32'hF00_0005, 1'b0, 2'b01, 1'b1, 32'h0, 0);
        chk("lh 5 rdata", last_rdata, 32'h0000_7766);
        do_req("sw 1", 32'h1, 1'b1, 2'b10, 1'b0, 32'h1234_5678, 0);
        chk("sw mem0", mem[0], 32'h3456_7811);
        chk("sw mem1", mem[1], 32'h8877_6612);
        do_req("lw 0", 32'h0, 1'b0, 2'b10, 1'b1, 32'h0, 0);
        chk("lw 0 rdata", last_rdata, 32'h3456_7811);
        do_req("sb 9", 32'h9, 1'b1, 2'b00, 1'b0, 32'hFFFF_FF5A, 0);
        do_req("lw 8", 32'h8, 1'b0, 2'b10, 1'b0, 32'h0, 0);
        chk("lw 8 rdata", last_rdata, 32'h0000_5A00);
        cycle(idle_rec());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
